// File: rtl/sc_preamble_pkg.sv
// sc_preamble_pkg: shared definitions for the Schmidl-Cox preamble inserter.
// Holds settings-bus register offsets, the inserter state enumeration and
// the settings reset defaults.
package sc_preamble_pkg;

    // Settings register offsets relative to SR_BASE
    localparam logic [7:0] SR_CTRL     = 8'd0;
    localparam logic [7:0] SR_HALF_LEN = 8'd1;
    localparam logic [7:0] SR_WADDR    = 8'd2;
    localparam logic [7:0] SR_WDATA    = 8'd3;
    localparam logic [7:0] SR_GAP      = 8'd4;

    // Reset defaults
    localparam logic        EN_RST       = 1'b0;
    localparam int unsigned HALF_LEN_RST = 64;
    localparam int unsigned WADDR_RST    = 0;
    localparam int unsigned GAP_W        = 16;
    localparam int unsigned GAP_RST      = 0;

    typedef enum logic [2:0] {
        IDLE,
        PRE_A,
        PRE_B,
        PAYLOAD,
        GAP
    } state_e;

endpackage

// File: rtl/sc_preamble_ram.sv
// sc_preamble_ram: preamble sample store, 2^ADDR_W x DATA_W.
// One write port, one synchronous read port with read enable so the read
// register holds its word while the output stage is stalled. No reset.
//   clk      - clock
//   we_i     - write enable, waddr_i/wdata_i - write address/data
//   re_i     - read enable, raddr_i - read address
//   rdata_o  - registered read data
module sc_preamble_ram #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write and registered read; same-address collision returns either word
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/sc_preamble_insert.sv
// sc_preamble_insert: prepends a repeated training symbol (A, A; L samples
// each from a programmable RAM) to every input packet, forwards the payload
// and optionally appends G zero samples.
// Optional feature macro: SC_PREAMBLE_GAP_EN enables the GAP register/state.
// Ports:
//   clk, reset_n                  - clock, async active-low reset
//   set_stb/set_addr/set_data     - settings bus write
//   i_tdata/i_tlast/i_tvalid/i_tready - input sample stream
//   o_tdata/o_tlast/o_tvalid/o_tready - output sample stream (registered)
module sc_preamble_insert
    import sc_preamble_pkg::*;
#(
    parameter logic [7:0]  SR_BASE  = 8'd0,
    parameter int unsigned LEN_LOG2 = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);

    localparam int unsigned CNT_W = LEN_LOG2 + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(2 ** LEN_LOG2);

    // Settings bus decode
    logic wr_ctrl, wr_len, wr_waddr, wr_wdata;
    assign wr_ctrl  = set_stb && (set_addr == SR_BASE + SR_CTRL);
    assign wr_len   = set_stb && (set_addr == SR_BASE + SR_HALF_LEN);
    assign wr_waddr = set_stb && (set_addr == SR_BASE + SR_WADDR);
    assign wr_wdata = set_stb && (set_addr == SR_BASE + SR_WDATA);

    logic                enable_q;
    logic [CNT_W-1:0]    half_len_q;
    logic [LEN_LOG2-1:0] waddr_q;
    logic [CNT_W-1:0]    len_field;
    assign len_field = set_data[CNT_W-1:0];

    // Live settings registers; HALF_LEN saturates to the RAM depth
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= EN_RST;
            half_len_q <= CNT_W'(HALF_LEN_RST);
            waddr_q    <= LEN_LOG2'(WADDR_RST);
        end else begin
            if (wr_ctrl) enable_q <= set_data[0];
            if (wr_len)  half_len_q <= (len_field > MAX_LEN) ? MAX_LEN : len_field;
            if (wr_waddr) begin
                waddr_q <= set_data[LEN_LOG2-1:0];
            end else if (wr_wdata) begin
                waddr_q <= waddr_q + LEN_LOG2'(1);
            end
        end
    end

    // Preamble RAM
    logic                rd_en;
    logic [LEN_LOG2-1:0] rd_addr;
    logic [31:0]         rd_data;

    sc_preamble_ram #(
        .ADDR_W (LEN_LOG2),
        .DATA_W (32)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_wdata),
        .waddr_i (waddr_q),
        .wdata_i (set_data),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_w_q, len_w_d;
    logic [31:0]      o_tdata_q, o_tdata_d;
    logic             o_tlast_q, o_tlast_d;
    logic             o_tvalid_q, o_tvalid_d;
    logic             out_free;
    logic             pre_last;
    logic             gap_pend;

    assign out_free = !o_tvalid_q || o_tready;
    assign pre_last = (cnt_q == len_w_q - CNT_W'(1));
    assign i_tready = (state_q == PAYLOAD) && out_free;
    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tvalid = o_tvalid_q;

`ifdef SC_PREAMBLE_GAP_EN
    logic             wr_gap;
    logic [GAP_W-1:0] gap_q, gap_w_q, gap_w_d, gap_cnt_q, gap_cnt_d;
    logic             gap_last;
    assign wr_gap   = set_stb && (set_addr == SR_BASE + SR_GAP);
    assign gap_pend = (gap_w_q != '0);
    assign gap_last = (gap_cnt_q == gap_w_q - GAP_W'(1));

    // Gap settings, working copy and counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_q     <= GAP_W'(GAP_RST);
            gap_w_q   <= GAP_W'(GAP_RST);
            gap_cnt_q <= '0;
        end else begin
            if (wr_gap) gap_q <= set_data[GAP_W-1:0];
            gap_w_q   <= gap_w_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end
`else
    assign gap_pend = 1'b0;
`endif

    // Next-state and output-stage logic; the RAM read runs one cycle ahead
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_w_d    = len_w_q;
        o_tvalid_d = o_tvalid_q && !o_tready;
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        rd_en      = 1'b0;
        rd_addr    = '0;
`ifdef SC_PREAMBLE_GAP_EN
        gap_w_d    = gap_w_q;
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_tvalid) begin
                    len_w_d = half_len_q;
                    cnt_d   = '0;
`ifdef SC_PREAMBLE_GAP_EN
                    gap_w_d   = gap_q;
                    gap_cnt_d = '0;
`endif
                    if (enable_q && (half_len_q != '0)) begin
                        state_d = PRE_A;
                        rd_en   = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PRE_A, PRE_B: begin
                if (out_free) begin
                    o_tvalid_d = 1'b1;
                    o_tdata_d  = rd_data;
                    o_tlast_d  = 1'b0;
                    if (pre_last) begin
                        cnt_d   = '0;
                        state_d = (state_q == PRE_A) ? PRE_B : PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // Prefetch next word (index 0 again when restarting for half B)
                    rd_en   = 1'b1;
                    rd_addr = cnt_d[LEN_LOG2-1:0];
                end
            end
            PAYLOAD: begin
                if (out_free && i_tvalid) begin
                    o_tvalid_d = 1'b1;
                    o_tdata_d  = i_tdata;
                    o_tlast_d  = i_tlast && !gap_pend;
                    if (i_tlast) begin
                        state_d = gap_pend ? GAP : IDLE;
                    end
                end
            end
`ifdef SC_PREAMBLE_GAP_EN
            GAP: begin
                if (out_free) begin
                    o_tvalid_d = 1'b1;
                    o_tdata_d  = '0;
                    o_tlast_d  = gap_last;
                    if (gap_last) begin
                        gap_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, counters and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_w_q    <= CNT_W'(HALF_LEN_RST);
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            o_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_w_q    <= len_w_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            o_tvalid_q <= o_tvalid_d;
        end
    end

endmodule

// File: tb/tb_sc_preamble_insert.sv
// tb_sc_preamble_insert: directed bench for sc_preamble_insert.
// Expected output streams are built from hand-derived preamble/payload/gap
// sequences and compared sample by sample against a negedge monitor.
module tb_sc_preamble_insert;

    localparam logic [7:0] A_CTRL  = 8'd0;
    localparam logic [7:0] A_LEN   = 8'd1;
    localparam logic [7:0] A_WADDR = 8'd2;
    localparam logic [7:0] A_WDATA = 8'd3;
    localparam logic [7:0] A_GAP   = 8'd4;

    logic        clk;
    logic        reset_n;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    sc_preamble_insert dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int timeouts = 0;
    int viol = 0;
    bit rnd_ready = 1'b0;
    bit abort = 1'b0;
    int lat;

    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [31:0] got_d[$];
    logic        got_l[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Downstream ready: constant 1 or 50% random, changed just after posedge
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records transfers and AXI hold/stability violations
    initial begin
        logic        prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    if (!o_tvalid) viol++;
                    if (o_tdata !== prev_d || o_tlast !== prev_l) viol++;
                end
                if (o_tvalid && o_tready) begin
                    got_d.push_back(o_tdata);
                    got_l.push_back(o_tlast);
                end
                prev_stall = o_tvalid && !o_tready;
                prev_d     = o_tdata;
                prev_l     = o_tlast;
            end
        end
    end

    task automatic set_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            int budget;
            budget   = 2000;
            i_tvalid = 1'b1;
            i_tdata  = base + 32'(k);
            i_tlast  = (k == n - 1);
            @(negedge clk);
            while (!i_tready && budget > 0 && !abort) begin
                @(negedge clk);
                budget--;
            end
            if (abort) break;
            if (budget == 0) begin
                timeouts++;
                break;
            end
            @(posedge clk);
            #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    // Launch a packet and count negedges until o_tvalid first rises
    task automatic start_pkt(input int n, input logic [31:0] base, output int l);
        @(posedge clk);
        #1;
        fork
            send_pkt(n, base);
        join_none
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!o_tvalid && l < 50);
    endtask

    task automatic exp_pre(input int l);
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < l; i++) begin
                exp_d.push_back(32'(i + 1));
                exp_l.push_back(1'b0);
            end
        end
    endtask

    task automatic exp_pay(input int n, input logic [31:0] base, input logic last_here);
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(base + 32'(i));
            exp_l.push_back(last_here && (i == n - 1));
        end
    endtask

    task automatic exp_gap(input int g);
        for (int i = 0; i < g; i++) begin
            exp_d.push_back(32'd0);
            exp_l.push_back(i == g - 1);
        end
    endtask

    task automatic expect_stream(input string tag);
        int budget;
        int n;
        budget = 4000;
        while (got_d.size() < exp_d.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (6) @(negedge clk);
        chk({tag, " len"}, 32'(got_d.size()), 32'(exp_d.size()));
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s data[%0d]", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s last[%0d]", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
        end
        got_d.delete();
        got_l.delete();
        exp_d.delete();
        exp_l.delete();
    endtask

    task automatic wait_got(input int n);
        int budget;
        budget = 2000;
        while (got_d.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeouts++;
    endtask

    initial begin
        reset_n  = 1'b0;
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst o_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst o_tlast",  32'(o_tlast),  32'd0);
        chk("rst o_tdata",  o_tdata,       32'd0);
        chk("rst i_tready", 32'(i_tready), 32'd0);

        // RAM[k] = k+1 over the full depth; the pointer wraps back to 0
        set_write(A_WADDR, 32'd0);
        for (int k = 0; k < 128; k++) set_write(A_WDATA, 32'(k + 1));

        // L=64, enable, 10-sample packet
        set_write(A_CTRL, 32'd1);
        set_write(A_LEN, 32'd64);
        exp_pre(64);
        exp_pay(10, 32'h1000_0000, 1'b1);
        start_pkt(10, 32'h1000_0000, lat);
        chk("t1 latency", 32'(lat), 32'd3);
        expect_stream("t1");

        // Same with random backpressure
        rnd_ready = 1'b1;
        exp_pre(64);
        exp_pay(10, 32'h1100_0000, 1'b1);
        start_pkt(10, 32'h1100_0000, lat);
        chk("t2 latency", 32'(lat), 32'd3);
        expect_stream("t2");
        rnd_ready = 1'b0;

        // Bypass
        set_write(A_CTRL, 32'd0);
        exp_pay(5, 32'h2000_0000, 1'b1);
        start_pkt(5, 32'h2000_0000, lat);
        chk("t3 latency", 32'(lat), 32'd3);
        expect_stream("t3");

        // HALF_LEN above RAM depth saturates to 128
        set_write(A_CTRL, 32'd1);
        set_write(A_LEN, 32'd200);
        exp_pre(128);
        exp_pay(1, 32'h3000_0000, 1'b1);
        start_pkt(1, 32'h3000_0000, lat);
        expect_stream("sat");

        // HALF_LEN change mid-preamble takes effect on the next packet
        set_write(A_LEN, 32'd4);
        exp_pre(4);
        exp_pay(3, 32'h4000_0000, 1'b1);
        start_pkt(3, 32'h4000_0000, lat);
        wait_got(5);
        set_write(A_LEN, 32'd8);
        expect_stream("len_old");
        exp_pre(8);
        exp_pay(2, 32'h4100_0000, 1'b1);
        start_pkt(2, 32'h4100_0000, lat);
        expect_stream("len_new");

        // Gap: G=3, L=4, single-sample packet
        set_write(A_LEN, 32'd4);
        set_write(A_GAP, 32'd3);
        exp_pre(4);
`ifdef SC_PREAMBLE_GAP_EN
        exp_pay(1, 32'h5000_0000, 1'b0);
        exp_gap(3);
`else
        exp_pay(1, 32'h5000_0000, 1'b1);
`endif
        start_pkt(1, 32'h5000_0000, lat);
        expect_stream("gap");
        set_write(A_GAP, 32'd0);

        // Asynchronous reset in the middle of the payload
        start_pkt(20, 32'h6000_0000, lat);
        wait_got(12);
        chk("pre-rst i_tready", 32'(i_tready), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst o_tvalid", 32'(o_tvalid), 32'd0);
        chk("arst i_tready", 32'(i_tready), 32'd0);
        chk("arst o_tlast",  32'(o_tlast),  32'd0);
        chk("arst o_tdata",  o_tdata,       32'd0);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        got_d.delete();
        got_l.delete();
        chk("post-rst o_tvalid", 32'(o_tvalid), 32'd0);
        set_write(A_CTRL, 32'd1);
        set_write(A_LEN, 32'd4);
        exp_pre(4);
        exp_pay(2, 32'h7000_0000, 1'b1);
        start_pkt(2, 32'h7000_0000, lat);
        chk("post-rst latency", 32'(lat), 32'd3);
        expect_stream("post_rst");

        chk("drv timeouts", 32'(timeouts), 32'd0);
        chk("axi hold rules", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
